// File: rtl/ripple_carry_adder_4bit_if.sv
// rtl/ripple_carry_adder_4bit_if.sv - operand/result bundle for the 4-bit ripple-carry adder
interface ripple_carry_adder_4bit_if;
  logic       i_valid;
  logic [3:0] i_a;
  logic [3:0] i_b;
  logic       i_carry_in;
  logic [3:0] o_s;
  logic       o_carry_out;
  logic       o_valid;

  modport master (
    output i_valid, i_a, i_b, i_carry_in,
    input  o_s, o_carry_out, o_valid
  );

  modport slave (
    input  i_valid, i_a, i_b, i_carry_in,
    output o_s, o_carry_out, o_valid
  );
endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// rtl/ripple_carry_adder_4bit.sv - 4-bit ripple-carry adder built from full-adder cells, registered output
module rca_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module rca_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  logic g;
  logic t;

  rca_half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(p), .c_o(g));
  rca_half_adder u_ha1 (.a_i(p), .b_i(c_i), .s_o(s_o), .c_o(t));

  assign c_o = g | t;
endmodule

module ripple_carry_adder_4bit (
  input  logic                           i_clk,
  input  logic                           i_reset,
  ripple_carry_adder_4bit_if.slave       bus
);
  logic [4:0] carry;
  logic [3:0] sum;

  logic [3:0] s_q, s_d;
  logic       cout_q, cout_d;
  logic       valid_q, valid_d;

  assign carry[0] = bus.i_carry_in;

  // Carry ripples stage to stage; carry[4] is the adder's carry out.
  for (genvar k = 0; k < 4; k++) begin : g_stage
    rca_full_adder u_fa (
      .a_i(bus.i_a[k]),
      .b_i(bus.i_b[k]),
      .c_i(carry[k]),
      .s_o(sum[k]),
      .c_o(carry[k+1])
    );
  end

  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (bus.i_valid) begin
      s_d     = sum;
      cout_d  = carry[4];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s_q     <= 4'b0000;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_s         = s_q;
  assign bus.o_carry_out = cout_q;
  assign bus.o_valid     = valid_q;
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// tb/tb_ripple_carry_adder_4bit.sv - randomized and directed self-checking bench for ripple_carry_adder_4bit
module tb_ripple_carry_adder_4bit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [4:0] held = 5'd0;

  always #5 clk = ~clk;

  ripple_carry_adder_4bit_if bus();

  ripple_carry_adder_4bit dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b, input bit c);
    bus.i_valid    = v;
    bus.i_a        = a;
    bus.i_b        = b;
    bus.i_carry_in = c;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      obs = {bus.o_valid, bus.o_carry_out, bus.o_s};
      n_cmp++;
      if (obs !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want 000000", i, obs);
      end
    end
    rst = 1'b0;
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    obs = {bus.o_valid, bus.o_carry_out, bus.o_s};
    n_cmp++;
    if (obs !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_first_op: got %b want 100000", obs);
    end
    held = 5'd0;
  endtask

  task automatic test_vectors(input string name, input logic [3:0] av[], input logic [3:0] bv[], input bit cv[]);
    logic [5:0] obs;
    logic [5:0] exp;
    int         total;
    for (int i = 0; i < av.size(); i++) begin
      drive(1'b1, av[i], bv[i], cv[i]);
      tick();
      total = int'(av[i]) + int'(bv[i]) + int'(cv[i]);
      held  = 5'(total);
      exp   = {1'b1, held};
      obs   = {bus.o_valid, bus.o_carry_out, bus.o_s};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s[%0d] a=%b b=%b cin=%b: got %b want %b", name, i, av[i], bv[i], cv[i], obs, exp);
      end
    end
  endtask

  task automatic test_no_carry();
    test_vectors("no_carry", '{4'b1010, 4'b1100}, '{4'b0001, 4'b0000}, '{1'b0, 1'b1});
  endtask

  task automatic test_full_ripple();
    test_vectors("full_ripple", '{4'b0101}, '{4'b1010}, '{1'b1});
  endtask

  task automatic test_back_to_back();
    test_vectors("overflow_max", '{4'b0111, 4'b1111}, '{4'b1100, 4'b1111}, '{1'b0, 1'b1});
  endtask

  task automatic test_hold();
    logic [5:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      obs = {bus.o_valid, bus.o_carry_out, bus.o_s};
      n_cmp++;
      if (obs !== {1'b0, held}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %b want %b", i, obs, {1'b0, held});
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [5:0] obs;
    rst = 1'b1;
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    tick();
    obs = {bus.o_valid, bus.o_carry_out, bus.o_s};
    n_cmp++;
    if (obs !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_priority: got %b want 000000", obs);
    end
    rst  = 1'b0;
    held = 5'd0;
  endtask

  task automatic test_exhaustive();
    logic [5:0] obs;
    int         total;
    int         bad = 0;
    for (int n = 0; n < 512; n++) begin
      drive(1'b1, 4'(n >> 5), 4'(n >> 1), 1'(n));
      tick();
      total = (n >> 5) + ((n >> 1) & 15) + (n & 1);
      held  = 5'(total);
      obs   = {bus.o_valid, bus.o_carry_out, bus.o_s};
      n_cmp++;
      if (obs !== {1'b1, held}) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL exhaustive n=%0d: got %b want %b", n, obs, {1'b1, held});
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] obs;
    logic [5:0] exp;
    logic [3:0] a, b;
    bit         c, v, r;
    int         bad = 0;
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 15) == 0);
      rst = r;
      drive(v, a, b, c);
      tick();
      if (r) begin
        held = 5'd0;
        exp  = 6'b000000;
      end else if (v) begin
        held = 5'(int'(a) + int'(b) + int'(c));
        exp  = {1'b1, held};
      end else begin
        exp  = {1'b0, held};
      end
      obs = {bus.o_valid, bus.o_carry_out, bus.o_s};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] rst=%b v=%b a=%b b=%b c=%b: got %b want %b", i, r, v, a, b, c, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    test_reset();
    test_no_carry();
    test_full_ripple();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    test_no_carry();
    test_hold();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
